// File: rtl/goomba_array_mover_if.sv
// goomba_array_mover_if
// Bundles the playfield inputs and per-Goomba outputs of goomba_array_mover.
//   background      tile map [row][col], one byte per tile
//   mario_x/y       Mario top-left position, pixels
//   mario_falling   Mario is moving downward
//   goomba_x/y      per-Goomba top-left position
//   goomba_alive    per-Goomba: walking or squashed
//   goomba_squashed per-Goomba: squashed, still visible
//   stomp           one-cycle strobe per stomp
//   lose            sticky loss flag
//   all_cleared     every Goomba is gone
// Handshake: this bus has no valid/ready pair. Mario inputs are level-sampled
// only in the cycle a Goomba is serviced; stomp is a single-cycle strobe and
// every other output is registered state, valid in every cycle.
interface goomba_array_mover_if #(
    parameter int NUM_GOOMBAS = 4
);
    logic [11:0][16:0][7:0]   background;
    int                       mario_x;
    int                       mario_y;
    logic                     mario_falling;
    int                       goomba_x [NUM_GOOMBAS];
    int                       goomba_y [NUM_GOOMBAS];
    logic [NUM_GOOMBAS-1:0]   goomba_alive;
    logic [NUM_GOOMBAS-1:0]   goomba_squashed;
    logic                     stomp;
    logic                     lose;
    logic                     all_cleared;

    modport master (
        output background, mario_x, mario_y, mario_falling,
        input  goomba_x, goomba_y, goomba_alive, goomba_squashed,
        input  stomp, lose, all_cleared
    );

    modport slave (
        input  background, mario_x, mario_y, mario_falling,
        output goomba_x, goomba_y, goomba_alive, goomba_squashed,
        output stomp, lose, all_cleared
    );
endinterface

// File: rtl/goomba_array_mover.sv
// goomba_array_mover
// Moves NUM_GOOMBAS Goombas along the ground row. A free-running tick counter
// divides vga_clock; every terminal count starts a scan that services one
// Goomba per cycle: stomp/loss resolution against Mario, then a one-step move
// that reverses on screen edges and solid tiles.
// Ports:
//   vga_clock   system clock
//   reset       asynchronous, active-high
//   bus         goomba_array_mover_if.slave (playfield in, Goomba state out)
//   scan_state  scan sequencer state (0 idle, 1 scanning)
module goomba_array_mover #(
    parameter int NUM_GOOMBAS     = 4,
    parameter int BDR             = 0,
    parameter int SKY             = 1,
    parameter int BLK             = 2,
    parameter int GND             = 3,
    parameter int CHARACTER_WIDTH = 42,
    parameter int SCREEN_WIDTH    = 640,
    parameter int BLOCK_WIDTH     = 40,
    parameter int GROUND_Y        = 360,
    parameter int STEP            = 1,
    parameter int TICK_DIVIDE     = 250000,
    parameter int SPAWN_X0        = 400,
    parameter int SPAWN_SPACING   = 60,
    parameter int SQUASH_TICKS    = 30,
    parameter int STOMP_MARGIN    = 12
) (
    input  logic                 vga_clock,
    input  logic                 reset,
    goomba_array_mover_if.slave  bus,
    output logic                 scan_state
);
    localparam int         IW  = (NUM_GOOMBAS > 1) ? $clog2(NUM_GOOMBAS) : 1;
    localparam logic [3:0] ROW = 4'(GROUND_Y / BLOCK_WIDTH);

    if (TICK_DIVIDE < NUM_GOOMBAS + 2) begin : g_bad_divide
        $error("TICK_DIVIDE must be at least NUM_GOOMBAS+2");
    end
    if (NUM_GOOMBAS < 1 || NUM_GOOMBAS > 8) begin : g_bad_count
        $error("NUM_GOOMBAS must be in 1..8");
    end
    if (BDR == SKY || BDR == BLK || BDR == GND || SKY == BLK || SKY == GND
        || BLK == GND) begin : g_bad_tiles
        $error("tile codes must be distinct");
    end

    typedef enum logic [1:0] {WALK_L, WALK_R, SQUASHED, DEAD} goomba_state_t;
    typedef enum logic {IDLE, SCAN} scan_state_t;

    int             x_q  [NUM_GOOMBAS];
    goomba_state_t  st_q [NUM_GOOMBAS];
    int             sq_q [NUM_GOOMBAS];
    int             tick_q;
    logic [IW-1:0]  idx_q;
    scan_state_t    scan_q, scan_d;
    logic           stomp_q, lose_q, cleared_q;

    logic           tick_done, last_idx, svc_en, all_dead;

    // service datapath for the Goomba selected by idx_q
    int             cur_x, cur_sq, dx, dy, nx, lead, col_raw, col_c;
    goomba_state_t  cur_st;
    logic [7:0]     tile;
    logic           overlap, stomp_hit, blocked;
    int             nxt_x, nxt_sq;
    goomba_state_t  nxt_st;
    logic           svc_stomp, svc_lose;

    // Only the ground row is consulted; fold the whole map so it is consumed.
    logic           unused_bits;
    assign unused_bits = ^bus.background;

    assign tick_done = (tick_q == TICK_DIVIDE - 1);
    assign last_idx  = (idx_q == IW'(NUM_GOOMBAS - 1));

    // ---------------- scan sequencer: state register ----------------
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) scan_q <= IDLE;
        else       scan_q <= scan_d;
    end

    // ---------------- scan sequencer: next state ----------------
    always_comb begin
        scan_d = scan_q;
        case (scan_q)
            IDLE:    if (tick_done) scan_d = SCAN;
            SCAN:    if (last_idx)  scan_d = IDLE;
            default: scan_d = IDLE;
        endcase
    end

    // ---------------- scan sequencer: outputs ----------------
    always_comb begin
        svc_en     = (scan_q == SCAN);
        scan_state = scan_q;
    end

    // ---------------- per-Goomba service ----------------
    always_comb begin
        cur_x  = x_q[idx_q];
        cur_st = st_q[idx_q];
        cur_sq = sq_q[idx_q];

        dx = bus.mario_x - cur_x;
        dy = bus.mario_y - GROUND_Y;
        overlap   = ((dx < 0) ? -dx : dx) < CHARACTER_WIDTH
                 && ((dy < 0) ? -dy : dy) < CHARACTER_WIDTH;
        stomp_hit = overlap && bus.mario_falling
                 && (bus.mario_y + CHARACTER_WIDTH <= GROUND_Y + STOMP_MARGIN);

        nx   = (cur_st == WALK_L) ? cur_x - STEP : cur_x + STEP;
        // leading edge is the pixel column the Goomba is walking into
        lead = (cur_st == WALK_L) ? nx : nx + CHARACTER_WIDTH - 1;
        col_raw = lead / BLOCK_WIDTH;
        if (col_raw < 0)       col_c = 0;
        else if (col_raw > 16) col_c = 16;
        else                   col_c = col_raw;
        tile    = bus.background[ROW][5'(col_c)];
        blocked = (nx < 0) || (nx + CHARACTER_WIDTH > SCREEN_WIDTH)
               || (tile == 8'(BLK)) || (tile == 8'(GND));

        nxt_x     = cur_x;
        nxt_st    = cur_st;
        nxt_sq    = cur_sq;
        svc_stomp = 1'b0;
        svc_lose  = 1'b0;
        case (cur_st)
            WALK_L, WALK_R: begin
                if (stomp_hit) begin
                    nxt_st    = SQUASHED;
                    nxt_sq    = 0;
                    svc_stomp = 1'b1;
                end else begin
                    svc_lose = overlap;
                    if (blocked) nxt_st = (cur_st == WALK_L) ? WALK_R : WALK_L;
                    else         nxt_x  = nx;
                end
            end
            SQUASHED: begin
                nxt_sq = cur_sq + 1;
                if (cur_sq + 1 >= SQUASH_TICKS) nxt_st = DEAD;
            end
            default: ;
        endcase
    end

    always_comb begin
        all_dead = 1'b1;
        for (int i = 0; i < NUM_GOOMBAS; i++) begin
            if (st_q[i] != DEAD) all_dead = 1'b0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            tick_q    <= 0;
            idx_q     <= '0;
            stomp_q   <= 1'b0;
            lose_q    <= 1'b0;
            cleared_q <= 1'b0;
            for (int i = 0; i < NUM_GOOMBAS; i++) begin
                x_q[i]  <= SPAWN_X0 + i * SPAWN_SPACING;
                st_q[i] <= WALK_L;
                sq_q[i] <= 0;
            end
        end else begin
            tick_q <= tick_done ? 0 : tick_q + 1;
            if (tick_done && scan_q == IDLE) idx_q <= '0;
            else if (svc_en)                 idx_q <= idx_q + 1'b1;
            stomp_q <= svc_en && svc_stomp;
            if (svc_en && svc_lose) lose_q <= 1'b1;
            // registered one cycle behind the last Goomba entering DEAD
            cleared_q <= all_dead;
            for (int i = 0; i < NUM_GOOMBAS; i++) begin
                if (svc_en && idx_q == IW'(i)) begin
                    x_q[i]  <= nxt_x;
                    st_q[i] <= nxt_st;
                    sq_q[i] <= nxt_sq;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        for (int i = 0; i < NUM_GOOMBAS; i++) begin
            bus.goomba_x[i]        = x_q[i];
            bus.goomba_y[i]        = GROUND_Y;
            bus.goomba_alive[i]    = (st_q[i] != DEAD);
            bus.goomba_squashed[i] = (st_q[i] == SQUASHED);
        end
        bus.stomp       = stomp_q;
        bus.lose        = lose_q;
        bus.all_cleared = cleared_q;
    end
endmodule

// File: tb/tb_goomba_array_mover.sv
module tb_goomba_array_mover;
    localparam int N    = 4;
    localparam int TD   = 8;
    localparam int CW   = 42;
    localparam int SW   = 640;
    localparam int BW   = 40;
    localparam int GY   = 360;
    localparam int STP  = 1;
    localparam int SX0  = 400;
    localparam int SSP  = 60;
    localparam int SQT  = 30;
    localparam int SM   = 12;
    localparam int SKY  = 1;
    localparam int BLK  = 2;
    localparam int GND  = 3;

    // ---------------- clock / reset ----------------
    logic vga_clock = 1'b0;
    logic reset     = 1'b1;
    logic scan_state;
    always #5 vga_clock = ~vga_clock;

    goomba_array_mover_if #(.NUM_GOOMBAS(N)) bus();

    goomba_array_mover #(.NUM_GOOMBAS(N), .TICK_DIVIDE(TD)) dut (
        .vga_clock  (vga_clock),
        .reset      (reset),
        .bus        (bus),
        .scan_state (scan_state)
    );

    logic [11:0][16:0][7:0] bg;
    assign bus.background = bg;

    // edges since reset release; terminal counts fall on multiples of TD
    int edge_cnt;
    always @(posedge vga_clock or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int                   due;
        logic [N-1:0][31:0]   xs;
        logic [N-1:0]         alive;
        logic [N-1:0]         squashed;
        logic                 stomp;
        logic                 lose;
        logic                 cleared;
    } exp_t;
    exp_t exp_q[$];

    int m_x   [N];
    int m_dir [N];
    int m_sq  [N];
    bit m_alive    [N];
    bit m_squashed [N];
    bit m_lose;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit model_all_dead();
        for (int i = 0; i < N; i++) if (m_alive[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = SX0 + i * SSP;
            m_dir[i] = -1;
            m_sq[i] = 0;
            m_alive[i] = 1'b1;
            m_squashed[i] = 1'b0;
        end
        m_lose = 1'b0;
    endtask

    function automatic exp_t snapshot(input int due, input bit stomped, input bit cleared);
        exp_t e;
        e.due = due;
        for (int j = 0; j < N; j++) begin
            e.xs[j]       = m_x[j];
            e.alive[j]    = m_alive[j];
            e.squashed[j] = m_squashed[j];
        end
        e.stomp   = stomped;
        e.lose    = m_lose;
        e.cleared = cleared;
        return e;
    endfunction

    // Advance the model through one scan starting at terminal edge k and queue
    // the state expected after each service edge.
    task automatic model_scan(input int k, input int mx, input int my, input bit mf);
        bit overlap, stomped, cleared_before;
        int nx, lead, col, tile;
        for (int i = 0; i < N; i++) begin
            stomped = 1'b0;
            cleared_before = model_all_dead();
            if (m_alive[i] && m_squashed[i]) begin
                m_sq[i]++;
                if (m_sq[i] == SQT) begin
                    m_alive[i] = 1'b0;
                    m_squashed[i] = 1'b0;
                end
            end else if (m_alive[i]) begin
                overlap = iabs(mx - m_x[i]) < CW && iabs(my - GY) < CW;
                if (overlap && mf && my + CW <= GY + SM) begin
                    m_squashed[i] = 1'b1;
                    m_sq[i] = 0;
                    stomped = 1'b1;
                end else begin
                    if (overlap) m_lose = 1'b1;
                    nx   = m_x[i] + m_dir[i] * STP;
                    lead = (m_dir[i] < 0) ? nx : nx + CW - 1;
                    col  = lead / BW;
                    if (col < 0)  col = 0;
                    if (col > 16) col = 16;
                    tile = int'(bg[4'(GY / BW)][5'(col)]);
                    if (nx < 0 || nx + CW > SW || tile == BLK || tile == GND)
                        m_dir[i] = -m_dir[i];
                    else
                        m_x[i] = nx;
                end
            end
            exp_q.push_back(snapshot(k + 1 + i, stomped, cleared_before));
        end
        exp_q.push_back(snapshot(k + 1 + N, 1'b0, model_all_dead()));
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t mon_e;
    always @(negedge vga_clock) begin
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
                mon_e = exp_q.pop_front();
                chk("late_record", edge_cnt, mon_e.due);
            end
            if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("x[%0d]@%0d", i, edge_cnt), bus.goomba_x[i], $signed(mon_e.xs[i]));
                    chk($sformatf("y[%0d]@%0d", i, edge_cnt), bus.goomba_y[i], GY);
                end
                chk($sformatf("alive@%0d", edge_cnt), 32'(bus.goomba_alive), 32'(mon_e.alive));
                chk($sformatf("squashed@%0d", edge_cnt), 32'(bus.goomba_squashed), 32'(mon_e.squashed));
                chk($sformatf("stomp@%0d", edge_cnt), 32'(bus.stomp), 32'(mon_e.stomp));
                chk($sformatf("lose@%0d", edge_cnt), 32'(bus.lose), 32'(mon_e.lose));
                chk($sformatf("cleared@%0d", edge_cnt), 32'(bus.all_cleared), 32'(mon_e.cleared));
            end else begin
                chk($sformatf("stomp_idle@%0d", edge_cnt), 32'(bus.stomp), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_state(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_x[%0d]", tag, i), bus.goomba_x[i], SX0 + i * SSP);
            chk($sformatf("%s_y[%0d]", tag, i), bus.goomba_y[i], GY);
        end
        chk({tag, "_alive"}, 32'(bus.goomba_alive), (1 << N) - 1);
        chk({tag, "_squashed"}, 32'(bus.goomba_squashed), 0);
        chk({tag, "_stomp"}, 32'(bus.stomp), 0);
        chk({tag, "_lose"}, 32'(bus.lose), 0);
        chk({tag, "_cleared"}, 32'(bus.all_cleared), 0);
    endtask

    task automatic set_mario(input int mx, input int my, input bit mf);
        bus.mario_x = mx;
        bus.mario_y = my;
        bus.mario_falling = mf;
    endtask

    task automatic do_reset(input string tag);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge vga_clock);
        check_reset_state(tag);
        reset = 1'b0;
    endtask

    // Drive Mario for one movement tick and wait for the whole scan to land.
    task automatic do_tick(input int mx, input int my, input bit mf);
        int k;
        @(negedge vga_clock);
        set_mario(mx, my, mf);
        k = (edge_cnt / TD + 1) * TD;
        model_scan(k, mx, my, mf);
        while (edge_cnt < k + N + 1) @(negedge vga_clock);
    endtask

    task automatic far_ticks(input int n);
        for (int t = 0; t < n; t++)
            do_tick($urandom_range(0, 639), $urandom_range(0, 200), 1'($urandom_range(0, 1)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                bg[r][c] = 8'(SKY);
        set_mario(0, 0, 1'b0);
        model_reset();
        repeat (3) @(negedge vga_clock);
        check_reset_state("reset");
        reset = 1'b0;

        // open ground: every Goomba steps left
        do_tick(0, 0, 1'b0);

        // block at column 9: Goomba 0 reverses at 400, then walks right
        do_reset("reset_blk");
        bg[9][9] = 8'(BLK);
        do_tick(0, 0, 1'b0);
        do_tick(0, 0, 1'b0);

        // long patrol with Mario out of reach: block reversals and right edge
        far_ticks(250);

        // stomp Goomba 0, let it expire; no loss recorded
        do_reset("reset_stomp");
        do_tick(399, 320, 1'b1);
        for (int t = 0; t < SQT; t++) do_tick(0, 0, 1'b0);

        // side contact sets a sticky loss
        do_tick(410, 360, 1'b0);
        do_tick(0, 0, 1'b0);

        // reset in the middle of a scan
        @(negedge vga_clock);
        set_mario(0, 0, 1'b0);
        k = (edge_cnt / TD + 1) * TD;
        model_scan(k, 0, 0, 1'b0);
        while (edge_cnt < k + 2) @(negedge vga_clock);
        #2 reset = 1'b1;
        #1 check_reset_state("midscan");
        exp_q.delete();
        model_reset();
        @(negedge vga_clock);
        reset = 1'b0;

        // stomp every Goomba, then wait for all_cleared
        for (int i = 0; i < N; i++) do_tick(m_x[i], 320, 1'b1);
        for (int t = 0; t < SQT + 2; t++) do_tick(0, 0, 1'b0);

        // random contact near the ground row
        do_reset("reset_rand");
        for (int t = 0; t < 80; t++)
            do_tick($urandom_range(300, 660), $urandom_range(280, 420), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge vga_clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/goomba_array_mover.md
# goomba_array_mover

Parametrised multi-enemy mover: owns NUM_GOOMBAS independent Goombas that patrol the ground row, reverse on blocks and screen edges, and resolve contact with Mario as either a stomp (Goomba squashed, then removed) or a loss. It sits beside the Mario movement logic, reads the same background tile map, and feeds per-Goomba positions and liveness to the renderer. Movement is divided down internally from vga_clock. Goombas are serviced one per cycle by a scan sequencer.

## Interface
- NUM_GOOMBAS, 4, number of Goombas (1..8)
- BDR/SKY/BLK/GND, 0/1/2/3, tile codes; BLK and GND are solid
- CHARACTER_WIDTH, 42, Goomba and Mario bounding-box side, pixels
- SCREEN_WIDTH, 640, playfield width, pixels
- BLOCK_WIDTH, 40, tile side, pixels
- GROUND_Y, 360, constant Goomba top y
- STEP, 1, pixels moved per movement tick
- TICK_DIVIDE, 250000, vga_clock cycles per movement tick; must be >= NUM_GOOMBAS+2
- SPAWN_X0, 400, reset x of Goomba 0
- SPAWN_SPACING, 60, reset x increment per Goomba index
- SQUASH_TICKS, 30, movement ticks a squashed Goomba stays visible
- STOMP_MARGIN, 12, max penetration of Mario's bottom below Goomba top that still counts as stomp
- vga_clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- background  in  byte [11:0][16:0]  tile map, [row][col]
- mario_x, mario_y  in  int  Mario top-left
- mario_falling  in  1  Mario vertical velocity is downward
- goomba_x  out  int [NUM_GOOMBAS]  top-left x
- goomba_y  out  int [NUM_GOOMBAS]  always GROUND_Y
- goomba_alive  out  [NUM_GOOMBAS]  1 while WALK or SQUASHED
- goomba_squashed  out  [NUM_GOOMBAS]  1 while SQUASHED
- stomp  out  1  one-cycle pulse per stomp
- lose  out  1  sticky loss flag
- all_cleared  out  1  every Goomba DEAD

## Operation
- Per-Goomba state: WALK_L, WALK_R, SQUASHED (tick counter), DEAD.
- Reset: goomba_x[i] = SPAWN_X0 + i*SPAWN_SPACING, state WALK_L, squash counter 0; stomp=0, lose=0, all_cleared=0, tick counter 0, scan idle.
- Tick counter counts 0..TICK_DIVIDE-1; at terminal count it wraps and starts a scan.
- Scan services i = 0..NUM_GOOMBAS-1, one per cycle, then returns to idle.
- Service of Goomba i in WALK state, in order:
  1. Overlap test: |mario_x - x| < CHARACTER_WIDTH and |mario_y - GROUND_Y| < CHARACTER_WIDTH.
  2. If overlap, mario_falling=1 and mario_y + CHARACTER_WIDTH <= GROUND_Y + STOMP_MARGIN: go to SQUASHED with counter 0, pulse stomp, no move.
  3. Else if overlap: set lose (sticky); Goomba still moves.
  4. Move: candidate nx = x - STEP (L) or x + STEP (R).
     - Blocked if nx < 0, or nx + CHARACTER_WIDTH > SCREEN_WIDTH, or the tile at row GROUND_Y/BLOCK_WIDTH and leading-edge column is BLK or GND.
     - Leading-edge column is nx/BLOCK_WIDTH (L) or (nx+CHARACTER_WIDTH-1)/BLOCK_WIDTH (R).
     - Blocked: flip direction, x unchanged. Otherwise x = nx.
- SQUASHED: counter increments per service; on reaching SQUASH_TICKS go DEAD (alive=0). No collision, no motion.
- DEAD: no effect; x frozen.
- Column arithmetic is signed 32-bit and is clamped to 0..16 before indexing.
- Stomp takes priority over lose in the same service.
- Multiple stomps in one scan each give a separate pulse, in consecutive cycles.
- lose clears only on reset.
- all_cleared is registered: set in the cycle after the last Goomba enters DEAD.

## Timing
- Terminal tick count at edge k; Goomba i's outputs update at edge k+1+i. stomp is high for the cycle following that edge.
- Mario inputs are sampled in the service cycle only; no synchronisation is applied.
- Asynchronous reset mid-scan aborts the scan; all outputs take reset values immediately. The first scan then starts after a full TICK_DIVIDE count.
- Elaboration fails if TICK_DIVIDE < NUM_GOOMBAS+2.

## Test plan
- Reset with TICK_DIVIDE=8, NUM_GOOMBAS=4, all-SKY row 9 -> x = 400,460,520,580; after one tick x = 399,459,519,579. Goomba 2 update lands 3 cycles after the terminal count.
- Put BLK at row 9 col 9; Goomba 0 at x=400 moving left -> at nx=399 it reverses with x held at 400, then moves to 401 next tick.
- Goomba 3 walking right from x=597 with STEP=1 -> reverses when nx+42 > 640 and never exceeds x=598.
- Mario at (399,320) with mario_falling=1 -> stomp pulses once, goomba_squashed[0]=1. After 30 ticks goomba_alive[0]=0, and lose stays 0.
- Mario at (410,360) with mario_falling=0 -> lose=1 and remains 1 after Mario leaves. Assert reset mid-scan -> lose=0 and x values return to spawn values immediately.
- Stomp all 4 Goombas and wait SQUASH_TICKS -> all_cleared=1 one cycle after the last enters DEAD.
